// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: decode-stage operand/destination info in, front-end stall, flush and forward controls out
interface id_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_wr;
    logic             id_rf_we;
    logic [1:0]       id_rf_wesl;
    logic             have_inst;
    logic             ex_redirect;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_rf_we, id_rf_wesl, have_inst, ex_redirect,
        input  stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_rf_we, id_rf_wesl, have_inst, ex_redirect,
        output stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: EX/MEM/WB destination scoreboard driving load-use stalls, redirect flushes and ALU forwarding
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    id_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] wr;
        logic       is_load;
    } ent_t;

    ent_t             ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu, redir, fid;

    function automatic logic hit(ent_t e, logic [4:0] r);
        return e.valid && e.wr != 5'd0 && e.wr == r;
    endfunction

    // EX load match selects the regfile: the load-use stall covers that case
    function automatic logic [1:0] sel(logic used, logic [4:0] r, ent_t ex, ent_t mem, ent_t wb);
        return (!used || r == 5'd0) ? 2'b00 :
               hit(ex, r)           ? (ex.is_load ? 2'b00 : 2'b01) :
               hit(mem, r)          ? 2'b10 :
               hit(wb, r)           ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        redir          = rst_n & bus.ex_redirect;
        lu             = rst_n & ex_q.is_load &
                         ((bus.id_rs1_used & hit(ex_q, bus.id_rs1)) | (bus.id_rs2_used & hit(ex_q, bus.id_rs2)));
        fid            = redir | lu;
        bus.flush_ifid = redir;
        bus.flush_idex = fid;
        bus.stall_pc   = lu & ~redir;
        bus.stall_ifid = lu & ~redir;
        bus.fwd_a      = rst_n ? sel(bus.id_rs1_used, bus.id_rs1, ex_q, mem_q, wb_q) : 2'b00;
        bus.fwd_b      = rst_n ? sel(bus.id_rs2_used, bus.id_rs2, ex_q, mem_q, wb_q) : 2'b00;
        ex_d           = fid ? ent_t'('0) : {bus.have_inst & bus.id_rf_we, bus.id_wr, bus.id_rf_wesl == 2'b01};
        mem_d          = ex_q;
        wb_d           = mem_q;
        stall_cnt_d    = stall_cnt_q + CNT_W'(lu & ~redir);
        flush_cnt_d    = flush_cnt_q + CNT_W'(redir);
        bus.stall_cnt  = stall_cnt_q;
        bus.flush_cnt  = flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
